fp_accumulator: RTL

Sequential IEEE-754 single-precision accumulator directly downstream of `FP_MULTIPLIER`. It consumes the registered product stream and sums one group of products into a running total, then presents the group result. Together the two blocks form the floating-point multiply-accumulate datapath. Addition is a fixed four-stage multi-cycle FSM: one product is in flight at a time.

---
 rtl/fp_accumulator.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_accumulator.sv
// fp_accumulator: sequential IEEE-754 single-precision accumulator that sits
// behind FP_MULTIPLIER and sums a group of products into a running total.
// One product is processed at a time through IDLE->ALIGN->ADD->NORM->ROUND.
// Denormal inputs are treated as signed zero and exponent 255 as infinity.
// Optional build macro: FP_ACC_ROUND_EN selects round-to-nearest-even;
// without it the result is truncated toward zero.
module fp_accumulator (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] acc_out,
  output logic        out_valid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4
  } state_t;

  // Right shift with every shifted-out bit folded into the sticky position.
  function automatic logic [27:0] align_shift(input logic [27:0] m,
                                              input logic [7:0]  d);
    logic [27:0] mask;
    logic [27:0] sh;
    if (d >= 8'd27) begin
      align_shift = {27'd0, |m};
    end else begin
      mask        = (28'd1 << d) - 28'd1;
      sh          = m >> d;
      align_shift = {sh[27:1], sh[0] | (|(m & mask))};
    end
  endfunction

  // Number of leading zeros above the highest set bit (input must be nonzero).
  function automatic logic [4:0] lead_zeros(input logic [26:0] m);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (m[i]) n = 5'(26 - i);
    end
    lead_zeros = n;
  endfunction

  // Rounding increment decision from lsb, guard, round and sticky.
  function automatic logic round_up(input logic lsb, input logic g,
                                    input logic r,   input logic s);
`ifdef FP_ACC_ROUND_EN
    round_up = g & (r | s | lsb);
`else
    // Truncation: the extra bits never cause an increment.
    round_up = 1'b0 & (lsb | g | r | s);
`endif
  endfunction

  // Control state
  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] acc_out_q, acc_out_d;
  logic        out_valid_q, out_valid_d;

  // Operand latch
  logic [31:0] op_q;
  logic        last_q;

  // ALIGN results
  logic        big_sign_q, big_sign_d;
  logic [7:0]  big_exp_q, big_exp_d;
  logic [27:0] big_man_q, big_man_d;
  logic        sml_sign_q, sml_sign_d;
  logic [27:0] sml_man_q, sml_man_d;
  logic        inf_q, inf_d;
  logic        inf_sign_q, inf_sign_d;
  logic        negz_q, negz_d;

  // ADD results
  logic [27:0] sum_q, sum_d;
  logic        sum_sign_q, sum_sign_d;

  // NORM results
  logic [26:0] nman_q, nman_d;
  logic [8:0]  nexp_q, nexp_d;
  logic        nzero_q, nzero_d;
  logic        nsign_q, nsign_d;

  // ROUND result
  logic [31:0] round_res;

  // ALIGN scratch
  logic        a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, swap;
  logic [7:0]  a_exp, b_exp, sml_exp, diff;
  logic [27:0] a_man, b_man, sml_raw;

  // NORM scratch
  logic [4:0]        lz;
  logic [26:0]       shifted;
  logic signed [9:0] nexp_s;

  // ROUND scratch
  logic        inc;
  logic [24:0] rsum;
  logic [22:0] rfrac;
  logic [8:0]  rexp;

  assign in_ready  = (state_q == S_IDLE);
  assign acc_out   = acc_out_q;
  assign out_valid = out_valid_q;

  // Next-state and accumulator/output update decisions.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: begin
        state_d = S_IDLE;
        if (last_q) begin
          acc_d       = 32'd0;
          acc_out_d   = round_res;
          out_valid_d = 1'b1;
        end else begin
          acc_d = round_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers: reset beats clear beats normal operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= 32'd0;
      acc_out_q   <= 32'd0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state_q     <= S_IDLE;
      acc_q       <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Capture the product and its group-end flag on the handshake.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && in_valid) begin
      op_q   <= in_data;
      last_q <= in_last;
    end
  end

  // ALIGN: unpack both operands, order by exponent, shift the smaller one.
  always_comb begin
    a_sign = acc_q[31];
    a_exp  = acc_q[30:23];
    b_sign = op_q[31];
    b_exp  = op_q[30:23];
    a_zero = (a_exp == 8'd0);
    b_zero = (b_exp == 8'd0);
    a_inf  = (a_exp == 8'hFF);
    b_inf  = (b_exp == 8'hFF);
    a_man  = a_zero ? 28'd0 : {2'b01, acc_q[22:0], 3'b000};
    b_man  = b_zero ? 28'd0 : {2'b01, op_q[22:0], 3'b000};
    swap   = (b_exp > a_exp);

    big_sign_d = swap ? b_sign : a_sign;
    big_exp_d  = swap ? b_exp  : a_exp;
    big_man_d  = swap ? b_man  : a_man;
    sml_sign_d = swap ? a_sign : b_sign;
    sml_exp    = swap ? a_exp  : b_exp;
    sml_raw    = swap ? a_man  : b_man;
    diff       = big_exp_d - sml_exp;
    sml_man_d  = align_shift(sml_raw, diff);

    // Opposite infinities resolve to +Inf; otherwise the infinite sign wins.
    inf_d      = a_inf | b_inf;
    inf_sign_d = (a_inf & b_inf) ? (a_sign & b_sign) : (a_inf ? a_sign : b_sign);
    negz_d     = a_zero & b_zero & a_sign & b_sign;
  end

  // ADD: magnitude add or subtract, keeping the result non-negative.
  always_comb begin
    if (big_sign_q == sml_sign_q) begin
      sum_d      = big_man_q + sml_man_q;
      sum_sign_d = big_sign_q;
    end else if (sml_man_q > big_man_q) begin
      sum_d      = sml_man_q - big_man_q;
      sum_sign_d = sml_sign_q;
    end else begin
      sum_d      = big_man_q - sml_man_q;
      sum_sign_d = big_sign_q;
    end
  end

  // NORM: fix carry-out or leading zeros, flush underflow to signed zero.
  always_comb begin
    lz      = lead_zeros(sum_q[26:0]);
    shifted = sum_q[26:0] << lz;
    nexp_s  = $signed({2'b00, big_exp_q}) - $signed({5'b00000, lz});
    nman_d  = 27'd0;
    nexp_d  = 9'd0;
    nzero_d = 1'b0;
    nsign_d = sum_sign_q;
    if (sum_q[27]) begin
      nman_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
      nexp_d = {1'b0, big_exp_q} + 9'd1;
    end else if (sum_q == 28'd0) begin
      nzero_d = 1'b1;
      nsign_d = negz_q;
    end else if (nexp_s <= 10'sd0) begin
      nzero_d = 1'b1;
    end else begin
      nman_d = shifted;
      nexp_d = nexp_s[8:0];
    end
  end

  // ROUND: apply rounding, re-normalise, saturate to infinity, pack.
  always_comb begin
    inc   = round_up(nman_q[3], nman_q[2], nman_q[1], nman_q[0]);
    rsum  = {1'b0, nman_q[26:3]} + {24'd0, inc};
    rfrac = rsum[24] ? rsum[23:1] : rsum[22:0];
    rexp  = nexp_q + {8'd0, rsum[24]};
    if (inf_q) begin
      round_res = {inf_sign_q, 8'hFF, 23'd0};
    end else if (nzero_q) begin
      round_res = {nsign_q, 31'd0};
    end else if (rexp >= 9'd255) begin
      round_res = {nsign_q, 8'hFF, 23'd0};
    end else begin
      round_res = {nsign_q, rexp[7:0], rfrac};
    end
  end

  // ALIGN -> ADD stage boundary.
  always_ff @(posedge clk) begin
    if (state_q == S_ALIGN) begin
      big_sign_q <= big_sign_d;
      big_exp_q  <= big_exp_d;
      big_man_q  <= big_man_d;
      sml_sign_q <= sml_sign_d;
      sml_man_q  <= sml_man_d;
      inf_q      <= inf_d;
      inf_sign_q <= inf_sign_d;
      negz_q     <= negz_d;
    end
  end

  // ADD -> NORM stage boundary.
  always_ff @(posedge clk) begin
    if (state_q == S_ADD) begin
      sum_q      <= sum_d;
      sum_sign_q <= sum_sign_d;
    end
  end

  // NORM -> ROUND stage boundary.
  always_ff @(posedge clk) begin
    if (state_q == S_NORM) begin
      nman_q  <= nman_d;
      nexp_q  <= nexp_d;
      nzero_q <= nzero_d;
      nsign_q <= nsign_d;
    end
  end

endmodule
